// File: rtl/mips_hazard_defs.sv
`default_nettype none
// ============================================================================
// Module      : mips_hazard_defs (package)
// Description : Shared encodings for the pipeline hazard controller:
//               execute-stage forward-mux selects and the memory-wait FSM
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_hazard_defs;

    // Execute-stage operand mux selects (2'b11 is never driven)
    localparam logic [1:0] FWD_RF  = 2'b00;  // register file read data
    localparam logic [1:0] FWD_WB  = 2'b01;  // W-stage result
    localparam logic [1:0] FWD_MEM = 2'b10;  // M-stage ALU result

    // Data-memory wait-state FSM
    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    // M-stage match takes priority over W-stage match
    function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
        if (hit_m)      return FWD_MEM;
        else if (hit_w) return FWD_WB;
        else            return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Shadow copy of E/M/W destination-register info, advanced in
//               lockstep with the pipeline registers the hazard unit controls.
//   i_hold_em   : memory stall - E and M hold, W takes a bubble
//   i_bubble_e  : hazard stall - E takes a bubble, M and W advance
//   i_*_d       : decode-stage fields loaded into E on a normal advance
//   o_*_e/m/w   : current shadow contents per stage
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_hold_em,
    input  logic              i_bubble_e,
    input  logic [REG_AW-1:0] i_rs_d,
    input  logic [REG_AW-1:0] i_rt_d,
    input  logic [REG_AW-1:0] i_dest_d,
    input  logic              i_regwrite_d,
    input  logic              i_memtoreg_d,
    output logic [REG_AW-1:0] o_rs_e,
    output logic [REG_AW-1:0] o_rt_e,
    output logic [REG_AW-1:0] o_dest_e,
    output logic              o_regwrite_e,
    output logic              o_memtoreg_e,
    output logic [REG_AW-1:0] o_dest_m,
    output logic              o_regwrite_m,
    output logic              o_memtoreg_m,
    output logic [REG_AW-1:0] o_dest_w,
    output logic              o_regwrite_w
);

    logic [REG_AW-1:0] r_rs_e, r_rt_e, r_dest_e, r_dest_m, r_dest_w;
    logic              r_regwrite_e, r_memtoreg_e;
    logic              r_regwrite_m, r_memtoreg_m;
    logic              r_regwrite_w;
    // The W-stage load flag has no consumer in the hazard logic, so only
    // dest/regwrite are shadowed there.

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rs_e       <= '0;
            r_rt_e       <= '0;
            r_dest_e     <= '0;
            r_regwrite_e <= 1'b0;
            r_memtoreg_e <= 1'b0;
            r_dest_m     <= '0;
            r_regwrite_m <= 1'b0;
            r_memtoreg_m <= 1'b0;
            r_dest_w     <= '0;
            r_regwrite_w <= 1'b0;
        end else if (i_hold_em) begin
            r_dest_w     <= '0;
            r_regwrite_w <= 1'b0;
        end else begin
            if (i_bubble_e) begin
                r_rs_e       <= '0;
                r_rt_e       <= '0;
                r_dest_e     <= '0;
                r_regwrite_e <= 1'b0;
                r_memtoreg_e <= 1'b0;
            end else begin
                r_rs_e       <= i_rs_d;
                r_rt_e       <= i_rt_d;
                r_dest_e     <= i_dest_d;
                r_regwrite_e <= i_regwrite_d;
                r_memtoreg_e <= i_memtoreg_d;
            end
            r_dest_m     <= r_dest_e;
            r_regwrite_m <= r_regwrite_e;
            r_memtoreg_m <= r_memtoreg_e;
            r_dest_w     <= r_dest_m;
            r_regwrite_w <= r_regwrite_m;
        end
    end

    assign o_rs_e       = r_rs_e;
    assign o_rt_e       = r_rt_e;
    assign o_dest_e     = r_dest_e;
    assign o_regwrite_e = r_regwrite_e;
    assign o_memtoreg_e = r_memtoreg_e;
    assign o_dest_m     = r_dest_m;
    assign o_regwrite_m = r_regwrite_m;
    assign o_memtoreg_m = r_memtoreg_m;
    assign o_dest_w     = r_dest_w;
    assign o_regwrite_w = r_regwrite_w;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Hazard controller for the five-stage MIPS pipeline.
//   Inputs : rs_d/rt_d/writereg_d + decode control, mem_req_m/mem_ready
//            (multi-cycle data memory handshake), perf_clr
//   Outputs: forward_a_e/forward_b_e (E operand mux selects),
//            forward_a_d/forward_b_d (branch-compare forward from M),
//            stall_f/d/e/m, flush_e/flush_w, stall_count (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import mips_hazard_defs::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic [REG_AW-1:0] writereg_d,
    input  logic              regwrite_d,
    input  logic              memtoreg_d,
    input  logic              branch_d,
    input  logic              mem_req_m,
    input  logic              mem_ready,
    input  logic              perf_clr,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              forward_a_d,
    output logic              forward_b_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_e,
    output logic              flush_w,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [REG_AW-1:0] w_rs_e, w_rt_e, w_dest_e, w_dest_m, w_dest_w;
    logic              w_regwrite_e, w_memtoreg_e;
    logic              w_regwrite_m, w_memtoreg_m, w_regwrite_w;
    logic              w_lwstall, w_brstall, w_hzstall, w_memstall;
    logic              w_e_hits_d, w_m_hits_d;
    hz_state_t         r_state, w_state_next;
    logic [CNT_W-1:0]  r_count;

    hazard_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .i_hold_em    (w_memstall),
        .i_bubble_e   (w_hzstall),
        .i_rs_d       (rs_d),
        .i_rt_d       (rt_d),
        .i_dest_d     (writereg_d),
        .i_regwrite_d (regwrite_d),
        .i_memtoreg_d (memtoreg_d),
        .o_rs_e       (w_rs_e),
        .o_rt_e       (w_rt_e),
        .o_dest_e     (w_dest_e),
        .o_regwrite_e (w_regwrite_e),
        .o_memtoreg_e (w_memtoreg_e),
        .o_dest_m     (w_dest_m),
        .o_regwrite_m (w_regwrite_m),
        .o_memtoreg_m (w_memtoreg_m),
        .o_dest_w     (w_dest_w),
        .o_regwrite_w (w_regwrite_w)
    );

    // Destination of E / M matches a decode source (never for $0)
    assign w_e_hits_d = (w_dest_e != '0) && ((w_dest_e == rs_d) || (w_dest_e == rt_d));
    assign w_m_hits_d = (w_dest_m != '0) && ((w_dest_m == rs_d) || (w_dest_m == rt_d));

    assign w_lwstall = w_memtoreg_e && w_e_hits_d;
    assign w_brstall = branch_d && ((w_regwrite_e && w_e_hits_d) || (w_memtoreg_m && w_m_hits_d));
    assign w_hzstall = w_lwstall || w_brstall;

    // Shadow regs are cleared by rst, but mem_req_m is a raw input, so the
    // memory stall is gated explicitly to keep every output low during reset.
    assign w_memstall = !rst && !mem_ready &&
                        (((r_state == ST_RUN) && mem_req_m) || (r_state == ST_MEM_WAIT));

    // Memory wait-state FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:      if (mem_req_m && !mem_ready) w_state_next = ST_MEM_WAIT;
            ST_MEM_WAIT: if (mem_ready)               w_state_next = ST_RUN;
            default:                                  w_state_next = ST_RUN;
        endcase
    end

    // Forwarding and stall/flush outputs
    always_comb begin
        forward_a_e = fwd_sel(w_rs_e != '0 && w_regwrite_m && w_rs_e == w_dest_m,
                              w_rs_e != '0 && w_regwrite_w && w_rs_e == w_dest_w);
        forward_b_e = fwd_sel(w_rt_e != '0 && w_regwrite_m && w_rt_e == w_dest_m,
                              w_rt_e != '0 && w_regwrite_w && w_rt_e == w_dest_w);
        forward_a_d = (rs_d != '0) && w_regwrite_m && (rs_d == w_dest_m);
        forward_b_d = (rt_d != '0) && w_regwrite_m && (rt_d == w_dest_m);
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (w_memstall) begin
            // Whole front of the pipe freezes; W drains a bubble
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (w_hzstall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               r_count <= '0;
        else if (perf_clr)                     r_count <= '0;
        else if (stall_f && r_count != c_CNT_MAX) r_count <= r_count + 1'b1;
    end

    assign stall_count = r_count;

endmodule
`default_nettype wire
